// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file, auto-incrementing pointer and read support,
// plus a parallel host port onto the same registers.
`timescale 1ns/1ps
module i2c_target_regfile #(
    parameter logic [6:0]   TARGET_ADDR = 7'h49,
    parameter int unsigned  NUM_REGS    = 16,
    parameter int unsigned  FILTER_LEN  = 3,
    localparam int unsigned AW          = $clog2(NUM_REGS)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_idx,
    output logic [7:0]    wr_data,
    output logic          busy
);

    localparam int unsigned CW = 3;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
    } state_t;

    // Index 0 carries SCL, index 1 carries SDA through the front end.
    logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]    filt_q, filt_d, prev_q, prev_d;
    logic [CW-1:0] fcnt_q [2];
    logic [CW-1:0] fcnt_d [2];

    state_t        state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          rw_q, rw_d;
    logic          phase_q, phase_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    host_rdata_q, host_rdata_d;
    logic [7:0]    regs_q [NUM_REGS];
    logic [7:0]    regs_d [NUM_REGS];
    logic          i2c_we;

    logic       scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in, rd_byte;

    // Synchroniser plus run-length glitch filter for both bus lines.
    always_comb begin
        sync1_d = {sda_in, scl_in};
        sync2_d = sync1_q;
        prev_d  = filt_q;
        filt_d  = filt_q;
        fcnt_d  = fcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] == CW'(FILTER_LEN - 1)) begin
                filt_d[i] = sync2_q[i];
                fcnt_d[i] = '0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + CW'(1);
            end
        end
    end

    assign scl_f     = filt_q[0];
    assign sda_f     = filt_q[1];
    assign scl_rise  = scl_f & ~prev_q[0];
    assign scl_fall  = ~scl_f & prev_q[0];
    assign start_det = scl_f & prev_q[0] & prev_q[1] & ~sda_f;
    assign stop_det  = scl_f & prev_q[0] & ~prev_q[1] & sda_f;
    assign byte_in   = {shift_q[6:0], sda_f};
    assign rd_byte   = regs_q[ptr_q];

    // Transaction FSM; ACK states use phase_q to split "drive ACK" and "release" falls.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        phase_d     = phase_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_idx_d    = wr_idx_q;
        wr_data_d   = wr_data_q;
        i2c_we      = 1'b0;

        if (start_det) begin
            state_d  = S_ADDR;
            bitcnt_d = '0;
            phase_d  = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d  = byte_in;
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            phase_d = 1'b0;
                            if (byte_in[7:1] == TARGET_ADDR) begin
                                state_d = S_ADDR_ACK;
                                rw_d    = byte_in[0];
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                            if (state_q == S_ADDR_ACK) begin
                                busy_d = 1'b1;
                            end
                        end else begin
                            phase_d  = 1'b0;
                            bitcnt_d = '0;
                            sda_oe_d = 1'b0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                state_d  = S_RDATA;
                                shift_d  = rd_byte;
                                sda_oe_d = ~rd_byte[7];
                            end else if (state_q == S_ADDR_ACK) begin
                                state_d = S_PTR;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end
                end
                S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        shift_d  = byte_in;
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            phase_d = 1'b0;
                            if (state_q == S_PTR) begin
                                state_d = S_PTR_ACK;
                                ptr_d   = byte_in[AW-1:0];
                            end else begin
                                state_d     = S_WDATA_ACK;
                                i2c_we      = 1'b1;
                                wr_strobe_d = 1'b1;
                                wr_idx_d    = ptr_q;
                                wr_data_d   = byte_in;
                                ptr_d       = ptr_q + AW'(1);
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_rise) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bitcnt_q == 4'd8) begin
                            state_d  = S_RACK;
                            phase_d  = 1'b0;
                            sda_oe_d = 1'b0;
                        end else begin
                            shift_d  = shift_q << 1;
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                // The byte just sent counts as consumed, so the pointer advances on ACK and NACK alike.
                S_RACK: begin
                    if (scl_rise && !phase_q) begin
                        ptr_d = ptr_q + AW'(1);
                        if (sda_f) begin
                            state_d = S_IGNORE;
                            busy_d  = 1'b0;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        state_d  = S_RDATA;
                        phase_d  = 1'b0;
                        bitcnt_d = '0;
                        shift_d  = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                    end
                end
                S_IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Register file: the I2C commit is applied last so it wins an index collision.
    always_comb begin
        regs_d = regs_q;
        if (host_we) begin
            regs_d[host_addr] = host_wdata;
        end
        if (i2c_we) begin
            regs_d[ptr_q] = byte_in;
        end
        host_rdata_d = regs_q[host_addr];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= 2'b11;
            sync2_q      <= 2'b11;
            filt_q       <= 2'b11;
            prev_q       <= 2'b11;
            fcnt_q       <= '{default: '0};
            state_q      <= S_IDLE;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            ptr_q        <= '0;
            rw_q         <= 1'b0;
            phase_q      <= 1'b0;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_idx_q     <= '0;
            wr_data_q    <= '0;
            host_rdata_q <= '0;
            regs_q       <= '{default: '0};
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            filt_q       <= filt_d;
            prev_q       <= prev_d;
            fcnt_q       <= fcnt_d;
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            ptr_q        <= ptr_d;
            rw_q         <= rw_d;
            phase_q      <= phase_d;
            sda_oe_q     <= sda_oe_d;
            busy_q       <= busy_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_idx_q     <= wr_idx_d;
            wr_data_q    <= wr_data_d;
            host_rdata_q <= host_rdata_d;
            regs_q       <= regs_d;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign busy       = busy_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_idx     = wr_idx_q;
    assign wr_data    = wr_data_q;
    assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C controller plus a transaction-level
// register/pointer model, with a per-cycle compare process on the host and commit ports.
`timescale 1ns/1ps
module tb_i2c_target_regfile;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       scl_c, sda_c, sda_bus;
    logic       sda_oe, busy, wr_strobe;
    logic       host_we;
    logic [3:0] host_addr, wr_idx;
    logic [7:0] host_wdata, host_rdata, wr_data;

    always #5 clock = ~clock;
    assign sda_bus = sda_c & ~sda_oe;

    i2c_target_regfile #(.TARGET_ADDR(7'h49), .NUM_REGS(16), .FILTER_LEN(3)) dut (
        .clock(clock), .reset_n(reset_n), .scl_in(scl_c), .sda_in(sda_bus),
        .sda_oe(sda_oe), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .wr_strobe(wr_strobe),
        .wr_idx(wr_idx), .wr_data(wr_data), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [16];
    logic [3:0]  model_ptr;
    logic [11:0] exp_q [$];
    logic [3:0]  idx_log [$];
    logic [7:0]  wbuf [8];
    logic [7:0]  rbuf [8];
    logic        expect_silent = 1'b0;
    logic        silent_viol   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Per-cycle compare: host_rdata latency, commit contents, and model register updates.
    initial begin : compare
        logic       pend_we;
        logic [3:0] pend_a;
        logic [7:0] pend_d, exp_r;
        logic [11:0] e;
        pend_we = 1'b0; pend_a = '0; pend_d = '0; exp_r = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                mem = '{default: 8'h00};
                exp_q.delete();
                pend_we = 1'b0;
                exp_r   = '0;
            end else begin
                chk("host_rdata", host_rdata, exp_r);
                if (pend_we) mem[pend_a] = pend_d;
                if (wr_strobe) begin
                    idx_log.push_back(wr_idx);
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_strobe: got idx %0h data %0h expected none", wr_idx, wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_idx", wr_idx, e[11:8]);
                        chk("wr_data", wr_data, e[7:0]);
                        mem[e[11:8]] = e[7:0];
                    end
                end
                if (expect_silent && (sda_oe || busy || wr_strobe)) silent_viol = 1'b1;
                pend_we = host_we; pend_a = host_addr; pend_d = host_wdata;
                exp_r = mem[host_addr];
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        wait_clk(1);
        host_we = 1'b0;
    endtask

    task automatic host_read(input logic [3:0] a, output logic [7:0] v);
        host_addr = a;
        wait_clk(1);
        v = host_rdata;
    endtask

    task automatic host_hold(input logic [3:0] a, input logic [7:0] d);
        logic found = 1'b0;
        host_addr = a; host_wdata = d; host_we = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            wait_clk(1);
            if (wr_strobe) begin found = 1'b1; break; end
        end
        host_we = 1'b0;
        chk("conflict_strobe_seen", found, 1);
    endtask

    // g: 0 plain, 1 two-cycle SCL low glitch while high, 2 one-cycle SDA dip while high.
    task automatic send_bit(input logic b, input int g);
        sda_c = b; wait_clk(8); scl_c = 1'b1;
        if (g == 1) begin
            wait_clk(6); scl_c = 1'b0; wait_clk(2); scl_c = 1'b1; wait_clk(8);
        end else if (g == 2) begin
            wait_clk(6); sda_c = 1'b0; wait_clk(1); sda_c = 1'b1; wait_clk(9);
        end else begin
            wait_clk(16);
        end
        scl_c = 1'b0; wait_clk(8);
    endtask

    task automatic recv_bit(output logic b);
        sda_c = 1'b1; wait_clk(8); scl_c = 1'b1; wait_clk(8);
        b = sda_bus;
        wait_clk(8); scl_c = 1'b0; wait_clk(8);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit glitch, output logic ack);
        for (int i = 7; i >= 0; i--)
            send_bit(d[i], !glitch ? 0 : (i == 4 ? 1 : (i == 2 ? 2 : 0)));
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack, 0);
    endtask

    task automatic i2c_start();
        sda_c = 1'b1; wait_clk(8); scl_c = 1'b1; wait_clk(16);
        sda_c = 1'b0; wait_clk(16); scl_c = 1'b0; wait_clk(8);
    endtask

    task automatic i2c_stop();
        sda_c = 1'b0; wait_clk(8); scl_c = 1'b1; wait_clk(16);
        sda_c = 1'b1; wait_clk(16);
    endtask

    task automatic do_write(input logic [6:0] a7, input logic [7:0] p, input int n, input bit glitch);
        logic ack;
        bit   m = (a7 == 7'h49);
        i2c_start();
        send_byte({a7, 1'b0}, 0, ack);
        chk("addr_ack", ack, m ? 0 : 1);
        if (m) chk("busy_on_match", busy, 1);
        send_byte(p, 0, ack);
        chk("ptr_ack", ack, m ? 0 : 1);
        if (m) model_ptr = p[3:0];
        for (int i = 0; i < n; i++) begin
            if (m) begin
                exp_q.push_back({model_ptr, wbuf[i]});
                model_ptr = model_ptr + 4'd1;
            end
            send_byte(wbuf[i], glitch, ack);
            chk("data_ack", ack, m ? 0 : 1);
        end
        i2c_stop();
        wait_clk(4);
        chk("busy_after_stop", busy, 0);
        chk("strobes_drained", exp_q.size(), 0);
    endtask

    task automatic do_read(input bit with_ptr, input logic [7:0] p, input int n);
        logic       ack;
        logic [7:0] d, e;
        i2c_start();
        if (with_ptr) begin
            send_byte(8'h92, 0, ack); chk("rd_waddr_ack", ack, 0);
            send_byte(p, 0, ack);     chk("rd_ptr_ack", ack, 0);
            model_ptr = p[3:0];
            i2c_start();
        end
        send_byte(8'h93, 0, ack);
        chk("rd_addr_ack", ack, 0);
        chk("rd_busy", busy, 1);
        for (int i = 0; i < n; i++) begin
            e = mem[model_ptr];
            model_ptr = model_ptr + 4'd1;
            recv_byte(d, (i == n - 1));
            rbuf[i] = d;
            chk("read_byte", d, e);
        end
        chk("busy_after_nack", busy, 0);
        i2c_stop();
        wait_clk(4);
    endtask

    initial begin : main
        logic       ack, b;
        logic [7:0] v;
        logic [6:0] a7;
        int         n;
        reset_n = 1'b0; scl_c = 1'b1; sda_c = 1'b1;
        host_we = 1'b0; host_addr = '0; host_wdata = '0;
        model_ptr = '0;
        wait_clk(3);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_strobe", wr_strobe, 0);
        chk("rst_wr_idx", wr_idx, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_host_rdata", host_rdata, 0);
        reset_n = 1'b1;
        wait_clk(10);

        // Write burst.
        idx_log.delete();
        wbuf[0] = 8'hA7; wbuf[1] = 8'h5C;
        do_write(7'h49, 8'h03, 2, 0);
        chk("burst_strobes", idx_log.size(), 2);
        if (idx_log.size() == 2) begin
            chk("burst_idx0", idx_log[0], 4'd3);
            chk("burst_idx1", idx_log[1], 4'd4);
        end
        host_read(4'd3, v); chk("lit_reg3", v, 8'hA7);
        host_read(4'd4, v); chk("lit_reg4", v, 8'h5C);

        // Combined read with repeated START; NACK on the second byte.
        host_write(4'd7, 8'h3C);
        host_write(4'd8, 8'hC3);
        host_write(4'd9, 8'h5A);
        do_read(1, 8'h07, 2);
        chk("lit_rd0", rbuf[0], 8'h3C);
        chk("lit_rd1", rbuf[1], 8'hC3);
        do_read(0, 8'h00, 1);
        chk("lit_ptr_after_nack", rbuf[0], 8'h5A);

        // Address mismatch stays silent.
        expect_silent = 1'b1; silent_viol = 1'b0;
        do_write(7'h4A, 8'hFF, 0, 0);
        expect_silent = 1'b0;
        chk("mismatch_silent", silent_viol, 0);

        // Pointer wrap and pointer truncation.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(7'h49, 8'h0F, 2, 0);
        host_read(4'd15, v); chk("lit_wrap15", v, 8'h11);
        host_read(4'd0, v);  chk("lit_wrap0", v, 8'h22);
        wbuf[0] = 8'h77;
        do_write(7'h49, 8'hF2, 1, 0);
        host_read(4'd2, v); chk("lit_ptr_f2", v, 8'h77);

        // Glitches on SCL and SDA inside a data byte.
        wbuf[0] = 8'hB6;
        do_write(7'h49, 8'h0A, 1, 1);
        host_read(4'd10, v); chk("lit_glitch", v, 8'hB6);

        // Host write colliding with an I2C commit on the same index.
        i2c_start();
        send_byte(8'h92, 0, ack); chk("cf_addr_ack", ack, 0);
        send_byte(8'h04, 0, ack); chk("cf_ptr_ack", ack, 0);
        model_ptr = 4'd4;
        exp_q.push_back({4'd4, 8'h5A});
        model_ptr = model_ptr + 4'd1;
        fork
            send_byte(8'h5A, 0, ack);
            host_hold(4'd4, 8'hEE);
        join
        chk("cf_data_ack", ack, 0);
        i2c_stop();
        wait_clk(4);
        host_read(4'd4, v); chk("lit_conflict", v, 8'h5A);

        // Randomised traffic against the model.
        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    n = $urandom_range(1, 3);
                    for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                    do_write(7'h49, 8'($urandom), n, 0);
                end
                1: do_read(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 3));
                2: begin
                    host_write(4'($urandom), 8'($urandom));
                    host_write(4'($urandom), 8'($urandom));
                end
                default: begin
                    a7 = 7'h49 ^ 7'($urandom_range(1, 127));
                    wbuf[0] = 8'($urandom);
                    expect_silent = 1'b1; silent_viol = 1'b0;
                    do_write(a7, 8'($urandom), 1, 0);
                    expect_silent = 1'b0;
                    chk("rand_mismatch_silent", silent_viol, 0);
                end
            endcase
        end

        // Reset in the middle of a read byte.
        host_write(4'd5, 8'hA5);
        i2c_start();
        send_byte(8'h92, 0, ack); chk("rr_addr_ack", ack, 0);
        send_byte(8'h05, 0, ack); chk("rr_ptr_ack", ack, 0);
        i2c_start();
        send_byte(8'h93, 0, ack); chk("rr_raddr_ack", ack, 0);
        recv_bit(b);
        chk("rr_bit7", b, 1);
        chk("rr_oe_bit6", sda_oe, 1);
        chk("rr_busy_pre", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("rr_oe_now", sda_oe, 0);
        chk("rr_busy_now", busy, 0);
        scl_c = 1'b1; sda_c = 1'b1;
        wait_clk(6);
        reset_n = 1'b1;
        model_ptr = '0;
        wait_clk(4);
        host_read(4'd5, v); chk("rr_reg5_cleared", v, 8'h00);
        host_read(4'd4, v); chk("rr_reg4_cleared", v, 8'h00);
        do_read(0, 8'h00, 1);
        chk("rr_ptr_reset_read", rbuf[0], 8'h00);

        wait_clk(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
